// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, flag bit positions and the NZVC flag record for alu_pipe.
package alu_pipe_pkg;

    localparam logic [3:0] OpXor  = 4'b0000;
    localparam logic [3:0] OpXnor = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0011;
    localparam logic [3:0] OpOr   = 4'b0100;
    localparam logic [3:0] OpNor  = 4'b0101;
    localparam logic [3:0] OpAnd  = 4'b0110;
    localparam logic [3:0] OpZero = 4'b0111;
    localparam logic [3:0] OpLsl  = 4'b1000;
    localparam logic [3:0] OpLsr  = 4'b1001;
    localparam logic [3:0] OpAsr  = 4'b1010;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagC = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the execute muxes, alu_pipe and writeback.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             in_cin;
    logic             in_use_carry;
    logic             in_set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_n;
    logic             out_z;
    logic             out_v;
    logic             out_c;
    logic [3:0]       flags;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, in_use_carry, in_set_flags, out_ready,
        input  in_ready, out_valid, out_result, out_n, out_z, out_v, out_c, flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, in_use_carry, in_set_flags, out_ready,
        output in_ready, out_valid, out_result, out_n, out_z, out_v, out_c, flags
    );
endinterface

// File: rtl/alu_pipe_blk.sv
// One carry-select slice: group generate/propagate plus sums for block carry-in 0 and 1.
module alu_pipe_blk #(
    parameter int unsigned BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    output logic           g,
    output logic           p,
    output logic [BLK-1:0] sum0,
    output logic [BLK-1:0] sum1
);
    logic [BLK:0] raw;

    assign raw  = {1'b0, a} + {1'b0, b};
    assign sum0 = raw[BLK-1:0];
    assign g    = raw[BLK];
    assign sum1 = raw[BLK-1:0] + BLK'(1);
    // A carry-in ripples straight through only when every bit pair differs.
    assign p    = &(a ^ b);
endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with architectural NZVC register and valid/ready on both sides.
// Define ALU_PIPE_SHIFT_EN to enable the LSL/LSR/ASR opcodes.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BLK   = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int unsigned NBLK = WIDTH / BLK;

    logic             s1_valid_q, s1_cin_q, s1_set_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [3:0]       s1_op_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_result_q;
    flags_t           s2_flags_q, flags_q;

    logic hazard, s1_adv, accept;

    // A carry consumer must wait until the flag-setting op ahead of it has committed.
    assign hazard       = s1_valid_q & s1_set_q & bus.in_valid & bus.in_use_carry;
    assign s1_adv       = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign bus.in_ready = (~s1_valid_q | s1_adv) & ~hazard;
    assign accept       = bus.in_valid & bus.in_ready;

    logic             is_arith;
    logic [WIDTH-1:0] b_eff, sum0, sum1, arith_sum, res;
    logic [NBLK-1:0]  blk_g, blk_p;
    logic             carry_out, carry_msb;
    flags_t           res_flags;

    assign is_arith = (s1_op_q == OpAdd) || (s1_op_q == OpSub);
    assign b_eff    = (s1_op_q == OpSub) ? ~s1_b_q : s1_b_q;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        alu_pipe_blk #(.BLK(BLK)) u_blk (
            .a    (s1_a_q[i*BLK +: BLK]),
            .b    (b_eff[i*BLK +: BLK]),
            .g    (blk_g[i]),
            .p    (blk_p[i]),
            .sum0 (sum0[i*BLK +: BLK]),
            .sum1 (sum1[i*BLK +: BLK])
        );
    end

    // Block-level lookahead over the group g/p terms selects each block's candidate sum.
    always_comb begin
        logic blk_carry;
        blk_carry = s1_cin_q;
        arith_sum = '0;
        for (int i = 0; i < NBLK; i++) begin
            arith_sum[i*BLK +: BLK] = blk_carry ? sum1[i*BLK +: BLK] : sum0[i*BLK +: BLK];
            blk_carry = blk_g[i] | (blk_p[i] & blk_carry);
        end
        carry_out = blk_carry;
    end

    assign carry_msb = arith_sum[WIDTH-1] ^ s1_a_q[WIDTH-1] ^ b_eff[WIDTH-1];

`ifdef ALU_PIPE_SHIFT_EN
    localparam int unsigned ShW = $clog2(WIDTH);
    logic [ShW-1:0] amt;
    assign amt = s1_b_q[ShW-1:0];
`endif

    always_comb begin
        res = '0;
        case (s1_op_q)
            OpXor:  res = s1_a_q ^ s1_b_q;
            OpXnor: res = ~(s1_a_q ^ s1_b_q);
            OpAdd,
            OpSub:  res = arith_sum;
            OpOr:   res = s1_a_q | s1_b_q;
            OpNor:  res = ~(s1_a_q | s1_b_q);
            OpAnd:  res = s1_a_q & s1_b_q;
`ifdef ALU_PIPE_SHIFT_EN
            OpLsl:  res = s1_a_q << amt;
            OpLsr:  res = s1_a_q >> amt;
            OpAsr:  res = $signed(s1_a_q) >>> amt;
`endif
            default: res = '0;
        endcase
        res_flags.n = res[WIDTH-1];
        res_flags.z = ~|res;
        res_flags.v = is_arith ? (carry_msb ^ carry_out) : flags_q.v;
        res_flags.c = is_arith ? carry_out : flags_q.c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_cin_q    <= 1'b0;
            s1_set_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            flags_q     <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= bus.in_a;
                s1_b_q     <= bus.in_b;
                s1_op_q    <= bus.in_op;
                s1_cin_q   <= bus.in_use_carry ? flags_q.c : bus.in_cin;
                s1_set_q   <= bus.in_set_flags;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid_q  <= 1'b1;
                s2_result_q <= res;
                s2_flags_q  <= res_flags;
                if (s1_set_q) begin
                    flags_q <= res_flags;
                end
            end else if (bus.out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_n      = s2_flags_q.n;
    assign bus.out_z      = s2_flags_q.z;
    assign bus.out_v      = s2_flags_q.v;
    assign bus.out_c      = s2_flags_q.c;
    assign bus.flags      = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic against a reference model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W), .BLK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   f;
    } exp_t;

    exp_t         exp_q[$];
    logic [3:0]   mflags = 4'b0;
    logic [W-1:0] last_res = '0;
    logic [3:0]   last_f = 4'b0;
    int           total = 0;
    int           bad = 0;
    int           n_out = 0;
    int           n_acc = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    // Architectural model: ops take effect in acceptance order, flags update immediately.
    task automatic model_accept();
        logic [W:0]   s;
        logic [W-1:0] a, b, r;
        logic         cin, arith, ovf;
        logic [3:0]   f;
        int           sh;
        exp_t         e;
        a     = bus.in_a;
        b     = (bus.in_op == OpSub) ? ~bus.in_b : bus.in_b;
        cin   = bus.in_use_carry ? mflags[FlagC] : bus.in_cin;
        sh    = int'(bus.in_b[5:0]);
        arith = 1'b0;
        s     = '0;
        case (bus.in_op)
            4'd0: r = a ^ b;
            4'd1: r = ~(a ^ b);
            4'd2, 4'd3: begin
                s     = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                r     = s[W-1:0];
                arith = 1'b1;
            end
            4'd4: r = a | b;
            4'd5: r = ~(a | b);
            4'd6: r = a & b;
`ifdef ALU_PIPE_SHIFT_EN
            4'd8:  r = a << sh;
            4'd9:  r = a >> sh;
            4'd10: r = (a >> sh) | (a[W-1] ? ~({W{1'b1}} >> sh) : '0);
`endif
            default: r = '0;
        endcase
        ovf       = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        f[FlagN]  = r[W-1];
        f[FlagZ]  = (r == '0);
        f[FlagV]  = arith ? ovf : mflags[FlagV];
        f[FlagC]  = arith ? s[W] : mflags[FlagC];
        if (bus.in_set_flags) mflags = f;
        e.res = r;
        e.f   = f;
        exp_q.push_back(e);
        n_acc++;
    endtask

    // Resolve this cycle's handshakes just before the edge, then advance to the next negedge.
    task automatic cycle();
        exp_t e;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            last_res = bus.out_result;
            last_f   = {bus.out_n, bus.out_z, bus.out_v, bus.out_c};
            if (exp_q.size() == 0) begin
                check("spurious_out", W'(n_out), W'(n_acc));
            end else begin
                e = exp_q.pop_front();
                check("result", bus.out_result, e.res);
                check("nzvc", W'(last_f), W'(e.f));
            end
        end
        if (bus.in_valid && bus.in_ready) model_accept();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic uc, input logic sf);
        bus.in_valid     = 1'b1;
        bus.in_op        = op;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_cin       = cin;
        bus.in_use_carry = uc;
        bus.in_set_flags = sf;
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic uc, input logic sf);
        logic done;
        done = 1'b0;
        drive(op, a, b, cin, uc, sf);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            done = bus.in_ready;
            cycle();
        end
        check("send_accepted", W'(done), W'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.out_valid); i++) cycle();
        check("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, ostart;
        logic [W-1:0] exp_shift;
        logic [3:0]   exp_shift_f;

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
        bus.in_cin = 1'b0; bus.in_use_carry = 1'b0; bus.in_set_flags = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_result", bus.out_result, '0);
        check("rst_out_nzvc", W'({bus.out_n, bus.out_z, bus.out_v, bus.out_c}), W'(0));
        check("rst_flags", W'(bus.flags), W'(0));
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", W'(bus.in_ready), W'(1));

        // Shift opcode behaviour depends on the build option; flags are still clear here.
`ifdef ALU_PIPE_SHIFT_EN
        exp_shift = 64'hF800_0000_0000_0000; exp_shift_f = 4'b1000;
`else
        exp_shift = 64'h0; exp_shift_f = 4'b0100;
`endif
        send(OpAsr, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 1'b0, 1'b0);
        drain();
        check("asr_res", last_res, exp_shift);
        check("asr_nzvc", W'(last_f), W'(exp_shift_f));

        // ADD overflow with latency check.
        drive(OpAdd, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        #1;
        check("add_ready", W'(bus.in_ready), W'(1));
        cycle();
        bus.in_valid = 1'b0;
        #1;
        check("lat_edge_k", W'(bus.out_valid), W'(0));
        cycle();
        #1;
        check("lat_edge_k1", W'(bus.out_valid), W'(1));
        check("add_flags_reg", W'(bus.flags), W'(4'b1010));
        cycle();
        check("add_res", last_res, 64'h8000_0000_0000_0000);
        check("add_nzvc", W'(last_f), W'(4'b1010));

        send(OpSub, 64'd5, 64'd5, 1'b1, 1'b0, 1'b1);
        drain();
        check("sub_res", last_res, 64'd0);
        check("sub_nzvc", W'(last_f), W'(4'b0101));
        check("sub_flags_reg", W'(bus.flags), W'(4'b0101));

        // ADDS then ADC back to back: exactly one bubble.
        bus.out_ready = 1'b1;
        drive(OpAdd, '1, 64'd1, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(OpAdd, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("hazard_stall", W'(bus.in_ready), W'(0));
        cycle();
        #1;
        check("hazard_clear", W'(bus.in_ready), W'(1));
        cycle();
        drain();
        check("adc_res", last_res, 64'd1);

        // Backpressure: two ops fill the pipe, then in_ready drops.
        bus.out_ready = 1'b0;
        start = n_acc;
        ostart = n_out;
        for (int i = 0; i < 4; i++) begin
            drive(OpAdd, W'((n_acc - start) * 3), 64'd100, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check("bp_accepted", W'(n_acc - start), W'(2));
        #1;
        check("bp_ready_low", W'(bus.in_ready), W'(0));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (n_acc - start) < 4; i++) begin
            drive(OpAdd, W'((n_acc - start) * 3), 64'd100, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drain();
        check("bp_delivered", W'(n_out - ostart), W'(4));
        check("bp_last_res", last_res, 64'd109);

        // Reset with two flag-setting ops in flight.
        bus.out_ready = 1'b0;
        start = n_acc;
        for (int i = 0; i < 4 && (n_acc - start) < 2; i++) begin
            if (n_acc == start) drive(OpAdd, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 1'b1);
            else drive(OpAdd, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
            cycle();
        end
        bus.in_valid = 1'b0;
        #1;
        check("pre_rst_flags", W'(bus.flags), W'(4'b1000));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", W'(bus.out_valid), W'(0));
        check("midrst_flags", W'(bus.flags), W'(0));
        exp_q.delete();
        mflags = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        ostart = n_out;
        repeat (5) cycle();
        check("post_rst_no_out", W'(n_out - ostart), W'(0));
        check("post_rst_flags", W'(bus.flags), W'(0));

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) != 0)
                drive(4'($urandom_range(0, 15)), rnd(), rnd(), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                bus.in_valid = 1'b0;
            cycle();
        end
        drain();
        check("final_flags", W'(bus.flags), W'(mflags));
        check("final_count", W'(n_out), W'(n_acc - 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
